// File: rtl/mega_mux_of_destiny.sv
// 32-bit, 16-way registered result selector for the vALU output.
// Each bit slice is a 4-layer 2:1 mux tree (8+4+2+1) steered by one select bit per layer.
module mega_mux_of_destiny #(
  parameter int WIDTH = 32,
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SEL_W-1:0] S,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic [WIDTH-1:0] I2,
  input  logic [WIDTH-1:0] I3,
  input  logic [WIDTH-1:0] I4,
  input  logic [WIDTH-1:0] I5,
  input  logic [WIDTH-1:0] I6,
  input  logic [WIDTH-1:0] I7,
  input  logic [WIDTH-1:0] I8,
  input  logic [WIDTH-1:0] I9,
  input  logic [WIDTH-1:0] I10,
  input  logic [WIDTH-1:0] I11,
  input  logic [WIDTH-1:0] I12,
  input  logic [WIDTH-1:0] I13,
  input  logic [WIDTH-1:0] I14,
  input  logic [WIDTH-1:0] I15,
  output logic [WIDTH-1:0] O
);

  logic [WIDTH-1:0] in_bus [16];
  logic [WIDTH-1:0] l1 [8];
  logic [WIDTH-1:0] l2 [4];
  logic [WIDTH-1:0] l3 [2];
  logic [WIDTH-1:0] l4;

  assign in_bus[0]  = I0;
  assign in_bus[1]  = I1;
  assign in_bus[2]  = I2;
  assign in_bus[3]  = I3;
  assign in_bus[4]  = I4;
  assign in_bus[5]  = I5;
  assign in_bus[6]  = I6;
  assign in_bus[7]  = I7;
  assign in_bus[8]  = I8;
  assign in_bus[9]  = I9;
  assign in_bus[10] = I10;
  assign in_bus[11] = I11;
  assign in_bus[12] = I12;
  assign in_bus[13] = I13;
  assign in_bus[14] = I14;
  assign in_bus[15] = I15;

  // Every bit slice is independent, so each layer is written as a vector-wide 2:1 mux.
  always_comb begin
    for (int j = 0; j < 8; j++) l1[j] = S[0] ? in_bus[2*j+1] : in_bus[2*j];
    for (int j = 0; j < 4; j++) l2[j] = S[1] ? l1[2*j+1] : l1[2*j];
    for (int j = 0; j < 2; j++) l3[j] = S[2] ? l2[2*j+1] : l2[2*j];
    l4 = S[3] ? l3[1] : l3[0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) O <= '0;
    else        O <= l4;
  end

endmodule

// File: tb/tb_mega_mux_of_destiny.sv
// Self-checking bench for mega_mux_of_destiny: vector table, hand-written
// corner sequences, and randomized traffic checked against an array-index model.
module tb_mega_mux_of_destiny;

  typedef struct {
    string       name;
    int          preset;
    logic        rst_n;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  s;
  logic [31:0] ins [16];
  logic [31:0] o;
  logic [31:0] exp_val;
  logic [31:0] prev_val;
  int          checks = 0;
  int          failures = 0;
  vec_t        tbl [$];

  always #5 clk = ~clk;

  mega_mux_of_destiny #(.WIDTH(32), .SEL_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .S(s),
    .I0(ins[0]),   .I1(ins[1]),   .I2(ins[2]),   .I3(ins[3]),
    .I4(ins[4]),   .I5(ins[5]),   .I6(ins[6]),   .I7(ins[7]),
    .I8(ins[8]),   .I9(ins[9]),   .I10(ins[10]), .I11(ins[11]),
    .I12(ins[12]), .I13(ins[13]), .I14(ins[14]), .I15(ins[15]),
    .O(o)
  );

  function automatic vec_t mk(input string name, input int preset, input logic r,
                              input logic [3:0] sel, input logic [31:0] exp);
    vec_t v;
    v.name = name; v.preset = preset; v.rst_n = r; v.sel = sel; v.exp = exp;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] exp);
    checks++;
    if (o !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, o, exp);
    end
  endtask

  // Drive on the falling edge; the model value is what the next rising edge must register.
  task automatic applyStimulus(input logic r, input logic [3:0] sel, output logic [31:0] exp);
    @(negedge clk);
    rst_n = r;
    s     = sel;
    exp   = r ? ins[sel] : 32'h0;
    @(posedge clk);
    #1;
  endtask

  task automatic loadPreset(input int preset);
    for (int k = 0; k < 16; k++) begin
      if (preset == 0) ins[k] = (k == 0) ? 32'h1 : (k == 1) ? 32'h2 : 32'h0;
      else             ins[k] = 32'h1 << k;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    s     = 4'd0;
    for (int k = 0; k < 16; k++) ins[k] = 32'h0;

    tbl.push_back(mk("reset_edge1", 0, 1'b0, 4'd1, 32'h0));
    tbl.push_back(mk("reset_edge2", 0, 1'b0, 4'd1, 32'h0));
    tbl.push_back(mk("sel0_i0",     0, 1'b1, 4'd0, 32'h1));
    tbl.push_back(mk("sel1_i1",     0, 1'b1, 4'd1, 32'h2));
    for (int k = 0; k < 16; k++)
      tbl.push_back(mk($sformatf("sweep_s%0d", k), 1, 1'b1, k[3:0], 32'h1 << k));

    foreach (tbl[i]) begin
      loadPreset(tbl[i].preset);
      applyStimulus(tbl[i].rst_n, tbl[i].sel, exp_val);
      checkOutput(tbl[i].name, tbl[i].exp);
    end

    // Walking ones then walking zeros on I5 while every other input is all-ones.
    for (int k = 0; k < 16; k++) ins[k] = 32'hFFFF_FFFF;
    for (int b = 0; b < 32; b++) begin
      ins[5] = 32'h1 << b;
      applyStimulus(1'b1, 4'd5, exp_val);
      checkOutput($sformatf("walk1_b%0d", b), 32'h1 << b);
    end
    for (int b = 0; b < 32; b++) begin
      ins[5] = ~(32'h1 << b);
      applyStimulus(1'b1, 4'd5, exp_val);
      checkOutput($sformatf("walk0_b%0d", b), ~(32'h1 << b));
    end

    for (int k = 0; k < 16; k++) ins[k] = 32'h0;
    ins[15] = 32'hDEAD_BEEF;
    applyStimulus(1'b1, 4'd15, exp_val);
    checkOutput("s15_steady", 32'hDEAD_BEEF);
    applyStimulus(1'b0, 4'd15, exp_val);
    checkOutput("s15_reset_pulse", 32'h0);
    applyStimulus(1'b1, 4'd15, exp_val);
    checkOutput("s15_resume", 32'hDEAD_BEEF);

    // Toggle 3 <-> 12; mid-cycle the register must still hold the previous pick.
    ins[3]   = 32'hA5A5_A5A5;
    ins[12]  = 32'h5A5A_5A5A;
    prev_val = 32'hDEAD_BEEF;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      s = (i % 2 == 0) ? 4'd3 : 4'd12;
      #1;
      checkOutput($sformatf("toggle_hold%0d", i), prev_val);
      @(posedge clk);
      #1;
      prev_val = (i % 2 == 0) ? 32'hA5A5_A5A5 : 32'h5A5A_5A5A;
      checkOutput($sformatf("toggle%0d", i), prev_val);
    end

    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < 16; k++) ins[k] = $urandom;
      applyStimulus(($urandom_range(0, 9) != 0), 4'($urandom_range(0, 15)), exp_val);
      checkOutput($sformatf("rand%0d", i), exp_val);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
